// File: rtl/if_fetch_ctrl.sv
// IF-stage PC register and single-outstanding instruction fetch controller.
// Optional misaligned-PC fetch exception enabled by defining IF_ADEL_EN.
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] pc_next_i,
  input  logic        branch_flag_i,
  input  logic        stall_i,
  output logic [31:0] pc_o,
  output logic        inst_req_o,
  output logic [31:0] inst_addr_o,
  input  logic        inst_addr_ok_i,
  input  logic        inst_data_ok_i,
  input  logic [31:0] inst_rdata_i,
`ifdef IF_ADEL_EN
  output logic        if_adel_o,
`endif
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o
);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
`ifdef IF_ADEL_EN
    StAdel,
`endif
    StHold
  } state_e;

  state_e      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic        r_pend, w_pend_nxt;
  logic [31:0] r_tgt, w_tgt_nxt;
  logic [31:0] r_buf_pc, w_buf_pc_nxt;
  logic [31:0] r_buf_inst, w_buf_inst_nxt;
  logic        r_valid, w_valid_nxt;
  logic [31:0] r_if_pc, r_if_inst;
  logic        w_load;
  logic [31:0] w_load_pc, w_load_inst;
  logic        w_slot_free;
`ifdef IF_ADEL_EN
  logic        r_adel, w_load_adel;
  logic        w_misal;

  assign w_misal   = (r_pc[1:0] != 2'b00);
  assign if_adel_o = r_adel;
`endif

  assign w_slot_free = !r_valid || !stall_i;

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_pend_nxt     = r_pend;
    w_tgt_nxt      = r_tgt;
    w_buf_pc_nxt   = r_buf_pc;
    w_buf_inst_nxt = r_buf_inst;
    w_load         = 1'b0;
    w_load_pc      = r_pc;
    w_load_inst    = inst_rdata_i;
`ifdef IF_ADEL_EN
    w_load_adel    = 1'b0;
`endif
    case (r_state)
      StIdle: begin
        w_state_nxt = StReq;
        if (branch_flag_i) w_pc_nxt = pc_next_i;
      end
      StReq: begin
`ifdef IF_ADEL_EN
        // No request goes out for a misaligned PC; nothing is in flight, so redirect directly.
        if (w_misal) begin
          if (branch_flag_i) begin
            w_pc_nxt = pc_next_i;
          end else if (w_slot_free) begin
            w_load      = 1'b1;
            w_load_inst = 32'h0;
            w_load_adel = 1'b1;
            w_state_nxt = StAdel;
          end
        end else
`endif
        begin
          if (inst_addr_ok_i) w_state_nxt = StWait;
          if (branch_flag_i) begin
            w_pend_nxt = 1'b1;
            w_tgt_nxt  = pc_next_i;
          end
        end
      end
      StWait: begin
        if (inst_data_ok_i) begin
          if (r_pend || branch_flag_i) begin
            w_pc_nxt    = branch_flag_i ? pc_next_i : r_tgt;
            w_pend_nxt  = 1'b0;
            w_state_nxt = StReq;
          end else if (w_slot_free) begin
            w_load      = 1'b1;
            w_pc_nxt    = pc_next_i;
            w_state_nxt = StReq;
          end else begin
            w_buf_pc_nxt   = r_pc;
            w_buf_inst_nxt = inst_rdata_i;
            w_state_nxt    = StHold;
          end
        end else if (branch_flag_i) begin
          w_pend_nxt = 1'b1;
          w_tgt_nxt  = pc_next_i;
        end
      end
      StHold: begin
        if (branch_flag_i) begin
          w_pc_nxt    = pc_next_i;
          w_state_nxt = StReq;
        end else if (!stall_i) begin
          w_load      = 1'b1;
          w_load_pc   = r_buf_pc;
          w_load_inst = r_buf_inst;
          w_pc_nxt    = pc_next_i;
          w_state_nxt = StReq;
        end
      end
`ifdef IF_ADEL_EN
      StAdel: begin
        if (branch_flag_i) begin
          w_pc_nxt    = pc_next_i;
          w_state_nxt = StReq;
        end
      end
`endif
      default: w_state_nxt = StIdle;
    endcase

    // A redirect flushes the output register regardless of stall or load.
    if (branch_flag_i)            w_valid_nxt = 1'b0;
    else if (w_load)              w_valid_nxt = 1'b1;
    else if (r_valid && !stall_i) w_valid_nxt = 1'b0;
    else                          w_valid_nxt = r_valid;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= StIdle;
      r_pc       <= RESET_PC;
      r_pend     <= 1'b0;
      r_tgt      <= 32'h0;
      r_buf_pc   <= 32'h0;
      r_buf_inst <= 32'h0;
      r_valid    <= 1'b0;
      r_if_pc    <= 32'h0;
      r_if_inst  <= 32'h0;
`ifdef IF_ADEL_EN
      r_adel     <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_pend     <= w_pend_nxt;
      r_tgt      <= w_tgt_nxt;
      r_buf_pc   <= w_buf_pc_nxt;
      r_buf_inst <= w_buf_inst_nxt;
      r_valid    <= w_valid_nxt;
      if (w_load && !branch_flag_i) begin
        r_if_pc   <= w_load_pc;
        r_if_inst <= w_load_inst;
`ifdef IF_ADEL_EN
        r_adel    <= w_load_adel;
`endif
      end
    end
  end

`ifdef IF_ADEL_EN
  assign inst_req_o  = (r_state == StReq) && !w_misal;
`else
  assign inst_req_o  = (r_state == StReq);
`endif
  assign inst_addr_o = r_pc;
  assign pc_o        = r_pc;
  assign if_valid_o  = r_valid;
  assign if_pc_o     = r_if_pc;
  assign if_inst_o   = r_if_inst;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl: fetch flow, addr_ok backpressure, redirects, hold buffer, reset.
module tb_if_fetch_ctrl;
  localparam logic [31:0] RstPc = 32'hBFC0_0000;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] pc_next_i;
  logic        branch_flag_i;
  logic        stall_i;
  logic [31:0] pc_o;
  logic        inst_req_o;
  logic [31:0] inst_addr_o;
  logic        inst_addr_ok_i;
  logic        inst_data_ok_i;
  logic [31:0] inst_rdata_i;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
`ifdef IF_ADEL_EN
  logic        if_adel_o;
`endif
  logic [31:0] tgt;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk_i = ~clk_i;

  // Minimal next-PC selector: sequential +4 unless redirecting.
  assign pc_next_i = branch_flag_i ? tgt : pc_o + 32'd4;

  if_fetch_ctrl #(.RESET_PC(RstPc)) u_dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .pc_next_i      (pc_next_i),
    .branch_flag_i  (branch_flag_i),
    .stall_i        (stall_i),
    .pc_o           (pc_o),
    .inst_req_o     (inst_req_o),
    .inst_addr_o    (inst_addr_o),
    .inst_addr_ok_i (inst_addr_ok_i),
    .inst_data_ok_i (inst_data_ok_i),
    .inst_rdata_i   (inst_rdata_i),
`ifdef IF_ADEL_EN
    .if_adel_o      (if_adel_o),
`endif
    .if_valid_o     (if_valid_o),
    .if_pc_o        (if_pc_o),
    .if_inst_o      (if_inst_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Request accepted immediately, data returned the following cycle.
  task automatic fetch(input logic [31:0] data);
    inst_addr_ok_i = 1'b1;
    step();
    inst_addr_ok_i = 1'b0;
    inst_data_ok_i = 1'b1;
    inst_rdata_i   = data;
    step();
    inst_data_ok_i = 1'b0;
  endtask

  initial begin
    rst_i          = 1'b0;
    branch_flag_i  = 1'b0;
    stall_i        = 1'b0;
    inst_addr_ok_i = 1'b0;
    inst_data_ok_i = 1'b0;
    inst_rdata_i   = 32'h0;
    tgt            = 32'h0;
    step();
    step();
    check("rst_pc", pc_o, RstPc);
    check("rst_req", {31'h0, inst_req_o}, 32'h0);
    check("rst_valid", {31'h0, if_valid_o}, 32'h0);
    check("rst_if_pc", if_pc_o, 32'h0);
    check("rst_if_inst", if_inst_o, 32'h0);

    // Back-to-back fetches with an immediately responding memory.
    rst_i = 1'b1;
    step();
    check("req_first", {31'h0, inst_req_o}, 32'h1);
    check("addr_first", inst_addr_o, 32'hBFC0_0000);
    fetch(32'h1111_0000);
    check("f0_valid", {31'h0, if_valid_o}, 32'h1);
    check("f0_pc", if_pc_o, 32'hBFC0_0000);
    check("f0_inst", if_inst_o, 32'h1111_0000);
    check("f0_next_addr", inst_addr_o, 32'hBFC0_0004);
    fetch(32'h1111_0001);
    check("f1_pc", if_pc_o, 32'hBFC0_0004);
    check("f1_inst", if_inst_o, 32'h1111_0001);
    fetch(32'h1111_0002);
    check("f2_pc", if_pc_o, 32'hBFC0_0008);
    check("f2_next_pc", pc_o, 32'hBFC0_000C);

    // addr_ok withheld: request and address held steady for four cycles.
    for (int i = 0; i < 3; i++) begin
      check("hold_req", {31'h0, inst_req_o}, 32'h1);
      check("hold_addr", inst_addr_o, 32'hBFC0_000C);
      step();
    end
    check("hold_req4", {31'h0, inst_req_o}, 32'h1);
    check("hold_pc4", pc_o, 32'hBFC0_000C);
    fetch(32'h1111_0003);
    check("f3_pc", if_pc_o, 32'hBFC0_000C);

    // Redirect while waiting for data: returned word is discarded.
    inst_addr_ok_i = 1'b1;
    step();
    inst_addr_ok_i = 1'b0;
    branch_flag_i  = 1'b1;
    tgt            = 32'hBFC0_0100;
    step();
    branch_flag_i = 1'b0;
    step();
    check("wait_req", {31'h0, inst_req_o}, 32'h0);
    inst_data_ok_i = 1'b1;
    inst_rdata_i   = 32'hDEAD_BEEF;
    step();
    inst_data_ok_i = 1'b0;
    check("drop_valid", {31'h0, if_valid_o}, 32'h0);
    check("drop_addr", inst_addr_o, 32'hBFC0_0100);
    check("drop_req", {31'h0, inst_req_o}, 32'h1);

    // Stall with a full output register pushes the next word into the hold buffer.
    fetch(32'h2222_0004);
    check("f4_pc", if_pc_o, 32'hBFC0_0100);
    stall_i = 1'b1;
    fetch(32'h2222_0005);
    check("hb_req", {31'h0, inst_req_o}, 32'h0);
    check("hb_valid", {31'h0, if_valid_o}, 32'h1);
    check("hb_if_pc", if_pc_o, 32'hBFC0_0100);
    step();
    check("hb_req2", {31'h0, inst_req_o}, 32'h0);
    stall_i = 1'b0;
    step();
    check("hb_out_pc", if_pc_o, 32'hBFC0_0104);
    check("hb_out_inst", if_inst_o, 32'h2222_0005);
    check("hb_out_valid", {31'h0, if_valid_o}, 32'h1);
    check("hb_resume_addr", inst_addr_o, 32'hBFC0_0108);
    check("hb_resume_req", {31'h0, inst_req_o}, 32'h1);

    // Redirect with both output register and hold buffer full, under stall.
    stall_i = 1'b1;
    fetch(32'h2222_0006);
    branch_flag_i = 1'b1;
    tgt           = 32'hBFC0_0200;
    step();
    branch_flag_i = 1'b0;
    stall_i       = 1'b0;
    check("flush_valid", {31'h0, if_valid_o}, 32'h0);
    check("flush_pc", pc_o, 32'hBFC0_0200);
    check("flush_req", {31'h0, inst_req_o}, 32'h1);
    fetch(32'h3333_0007);
    check("f7_pc", if_pc_o, 32'hBFC0_0200);
    check("f7_inst", if_inst_o, 32'h3333_0007);

    // Reset mid-fetch; late data_ok in IDLE/REQ is ignored.
    inst_addr_ok_i = 1'b1;
    step();
    inst_addr_ok_i = 1'b0;
    rst_i = 1'b0;
    #1;
    check("mid_rst_pc", pc_o, RstPc);
    check("mid_rst_valid", {31'h0, if_valid_o}, 32'h0);
    step();
    rst_i          = 1'b1;
    inst_data_ok_i = 1'b1;
    inst_rdata_i   = 32'hBAD0_BAD0;
    step();
    check("late_idle_valid", {31'h0, if_valid_o}, 32'h0);
    step();
    inst_data_ok_i = 1'b0;
    check("late_req_valid", {31'h0, if_valid_o}, 32'h0);
    check("late_req_addr", inst_addr_o, RstPc);

    // Redirect during REQ with the same-cycle accept: fetch completes but is dropped.
    branch_flag_i  = 1'b1;
    tgt            = 32'hBFC0_0300;
    inst_addr_ok_i = 1'b1;
    step();
    branch_flag_i  = 1'b0;
    inst_addr_ok_i = 1'b0;
    inst_data_ok_i = 1'b1;
    inst_rdata_i   = 32'hBAD1_BAD1;
    step();
    inst_data_ok_i = 1'b0;
    check("reqbr_valid", {31'h0, if_valid_o}, 32'h0);
    check("reqbr_addr", inst_addr_o, 32'hBFC0_0300);
    fetch(32'h4444_0008);
    check("f8_pc", if_pc_o, 32'hBFC0_0300);

`ifdef IF_ADEL_EN
    // Misaligned redirect target raises an address-error instruction instead of fetching.
    branch_flag_i  = 1'b1;
    tgt            = 32'hBFC0_0102;
    inst_addr_ok_i = 1'b1;
    step();
    branch_flag_i  = 1'b0;
    inst_addr_ok_i = 1'b0;
    inst_data_ok_i = 1'b1;
    step();
    inst_data_ok_i = 1'b0;
    check("adel_noreq", {31'h0, inst_req_o}, 32'h0);
    step();
    check("adel_valid", {31'h0, if_valid_o}, 32'h1);
    check("adel_flag", {31'h0, if_adel_o}, 32'h1);
    check("adel_pc", if_pc_o, 32'hBFC0_0102);
    check("adel_inst", if_inst_o, 32'h0);
    check("adel_noreq2", {31'h0, inst_req_o}, 32'h0);
    branch_flag_i = 1'b1;
    tgt           = 32'hBFC0_0400;
    step();
    branch_flag_i = 1'b0;
    check("adel_exit_req", {31'h0, inst_req_o}, 32'h1);
    check("adel_exit_addr", inst_addr_o, 32'hBFC0_0400);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
